trail_frame_sequencer: RTL
==========================

// Module: trail_frame_sequencer
// PURPOSE
//  Sequences one trail_iir update pass per video frame. Accepts camera pixels on a valid/ready stream
//  and reads the matching history pixel from the frame buffer. Presents both pixels to trail_iir, then
//  writes the updated pixel back to the same address. Sits between the camera pipeline, the history
//  BRAM and trail_iir in top_level.
// PARAMETERS
//  COLOR_DEPTH  8                        bits per pixel, matches trail_iir
//  H_PIXELS     320                      pixels per line
//  V_PIXELS     240                      lines per frame
//  MEM_LATENCY  2                        cycles from hist_rd_en_out to valid hist_data_in (>=1)
//  IIR_LATENCY  1                        cycles from iir_*_out to valid iir_update_in (>=0)
//  ADDR_WIDTH   $clog2(H_PIXELS*V_PIXELS) localparam, frame buffer address width
// PORTS
//  clk_in          in   1            system clock
//  rst_in          in   1            synchronous, active-high reset
//  start_in        in   1            pulse: begin a frame pass (honoured only in IDLE)
//  cam_valid_in    in   1            camera pixel valid
//  cam_pxl_in      in   COLOR_DEPTH  camera pixel, raster order
//  cam_ready_out   out  1            sequencer accepts camera pixel
//  hist_rd_en_out  out  1            history BRAM read strobe
//  hist_addr_out   out  ADDR_WIDTH   history read address
//  hist_data_in    in   COLOR_DEPTH  history read data, MEM_LATENCY after strobe
//  iir_history_out out  COLOR_DEPTH  to trail_iir history_in
//  iir_camera_out  out  COLOR_DEPTH  to trail_iir camera_in
//  iir_update_in   in   COLOR_DEPTH  from trail_iir update_out
//  wr_en_out       out  1            history BRAM write strobe
//  wr_addr_out     out  ADDR_WIDTH   write address
//  wr_data_out     out  COLOR_DEPTH  write data (= iir_update_in)
//  busy_out        out  1            high in RUN or DRAIN
//  frame_done_out  out  1            1-cycle pulse when last write of frame has issued
// BEHAVIOUR
//  - Clock clk_in; reset rst_in is synchronous and active-high. Reset forces state IDLE.
//    Reset clears address counter and every pipeline valid bit. All outputs reset to 0.
//  - FSM: IDLE -(start_in)-> RUN -(pixel N-1 accepted)-> DRAIN -(pipe empty)-> DONE -> IDLE.
//    N = H_PIXELS*V_PIXELS.
//  - cam_ready_out = (state==RUN), combinational from state. A handshake is cam_valid_in & cam_ready_out.
//  - On handshake at address a, in the same cycle: hist_rd_en_out=1, hist_addr_out=a. Address
//    increments by 1 per handshake. No handshake means no read; stalls are allowed on any cycle.
//  - cam_pxl_in, a and a valid bit travel in a MEM_LATENCY-deep shift register. At its output,
//    iir_camera_out=delayed pixel and iir_history_out=hist_data_in (registered outputs not allowed here,
//    i.e. aligned exactly with hist_data_in).
//  - Then a further IIR_LATENCY-deep delay of address+valid. At its output: wr_en_out=1,
//    wr_addr_out=a, wr_data_out=iir_update_in.
//  - Latency: handshake -> wr_en_out = MEM_LATENCY+IIR_LATENCY cycles. Throughput is 1 pixel/cycle.
//  - iir_*_out hold their last values when the pipe slot is invalid; wr_en_out=0 then.
//  - Last pixel (a==N-1) accepted: next state DRAIN, cam_ready_out drops the next cycle. The address
//    counter wraps to 0.
//  - DRAIN lasts until all valid bits are clear. DONE lasts exactly 1 cycle, frame_done_out=1 there.
//    The final write occurs in the last DRAIN cycle, before DONE.
//  - start_in outside IDLE: ignored. start_in together with rst_in: reset wins.
//  - Reset mid-frame: in-flight writes are discarded, none complete. The next start_in restarts at address 0.
//  - Read/write addresses never collide: each address is touched once per pass.
// CONFIGURATION
//  TRAIL_SEQ_STATS_EN defined: adds output frame_count_out[15:0]. Reset 0. Increments in DONE,
//    wraps 0xFFFF->0. Also adds stall_count_out[31:0], which counts RUN cycles with
//    cam_valid_in=0 and clears on start_in.
//  Undefined: those ports and counters do not exist; all other behaviour is identical.
// STRUCTURE
//  Package trail_pkg: typedef seq_state_t {IDLE,RUN,DRAIN,DONE}; typedef pixel_t
//    (logic [COLOR_DEPTH-1:0]) shared with trail_iir.
//  Sub-module: trail_delay_line (param WIDTH, DEPTH; valid+data shift register, sync clear).
//    It is instantiated twice, once for the MEM stage and once for the IIR stage (DEPTH=0 means pass-through).
// TESTING
//  Use H=4, V=2, MEM_LATENCY=2, IIR_LATENCY=1 with a BRAM model, and trail_iir replaced by update=camera^history.
//  1. Preload hist[i]=0x10*i, start, cam 0xA0..0xA7 continuous valid -> wr at addr i on cycle
//     accept+3, data 0xA0+i ^ 0x10*i. frame_done 1 cycle after the last write.
//  2. Random cam_valid gaps (50%) -> same 8 writes in order, no duplicates. busy is high throughout.
//  3. start_in pulsed during RUN and DRAIN -> ignored; the address sequence is unchanged.
//  4. rst_in after 3rd accept -> no wr_en for remaining in-flight pixels, state IDLE. A restart writes addr 0 first.
//  5. Two back-to-back passes -> second pass reads the first-pass results. With TRAIL_SEQ_STATS_EN, frame_count_out=2.
//  6. cam_valid high in IDLE/DONE -> cam_ready_out=0, no rd/wr strobes.

Source files
------------

// File: rtl/trail_pkg.sv
`default_nettype none
// ============================================================================
// Module      : trail_pkg
// Description : Shared types for the trail effect datapath: sequencer state
//               encoding and the pixel type exchanged with trail_iir.
// Revision    : 1.0 - initial release
// ============================================================================
package trail_pkg;

    localparam int c_COLOR_DEPTH = 8;

    typedef logic [c_COLOR_DEPTH-1:0] pixel_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } seq_state_t;

endpackage
`default_nettype wire

// File: rtl/trail_delay_line.sv
`default_nettype none
// ============================================================================
// Module      : trail_delay_line
// Description : Valid + payload shift register of DEPTH stages with a
//               synchronous clear of the valid bits. DEPTH = 0 is a plain
//               pass-through. 'pending' is high when any stage will hold a
//               valid beat on the next cycle that has not yet reached the
//               output (i.e. the line still has work after this cycle).
// Revision    : 1.0 - initial release
// ============================================================================
module trail_delay_line
    import trail_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int DEPTH = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             src_valid,
    input  logic [WIDTH-1:0] src_data,
    output logic             dst_valid,
    output logic [WIDTH-1:0] dst_data,
    output logic             pending
);

    generate
        if (DEPTH == 0) begin : g_pass
            assign dst_valid = src_valid;
            assign dst_data  = src_data;
            assign pending   = 1'b0;
        end else begin : g_shift
            // Every stage except the last one feeds another stage next cycle.
            localparam logic [DEPTH-1:0] c_INNER_MASK = {DEPTH{1'b1}} >> 1;

            logic [DEPTH-1:0] r_valid;
            logic [WIDTH-1:0] r_data [DEPTH];

            // Advance valid bits and payload one stage per clock; reset flushes.
            always_ff @(posedge clk) begin
                if (rst) begin
                    r_valid <= '0;
                    for (int i = 0; i < DEPTH; i++) begin
                        r_data[i] <= '0;
                    end
                end else begin
                    r_valid[0] <= src_valid;
                    r_data[0]  <= src_data;
                    for (int i = 1; i < DEPTH; i++) begin
                        r_valid[i] <= r_valid[i-1];
                        r_data[i]  <= r_data[i-1];
                    end
                end
            end

            assign dst_valid = r_valid[DEPTH-1];
            assign dst_data  = r_data[DEPTH-1];
            assign pending   = src_valid | (|(r_valid & c_INNER_MASK));
        end
    endgenerate

endmodule
`default_nettype wire

// File: rtl/trail_frame_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : trail_frame_sequencer
// Description : Runs one trail_iir update pass per frame. Each accepted
//               camera pixel issues a history read; once the read data
//               returns both pixels are shown to trail_iir, and the IIR
//               result is written back to the same address.
//               Optional macro TRAIL_SEQ_STATS_EN adds frame_count_out and
//               stall_count_out statistics counters.
// Revision    : 1.0 - initial release
// ============================================================================
module trail_frame_sequencer
    import trail_pkg::*;
#(
    parameter  int COLOR_DEPTH = 8,
    parameter  int H_PIXELS    = 320,
    parameter  int V_PIXELS    = 240,
    parameter  int MEM_LATENCY = 2,
    parameter  int IIR_LATENCY = 1,
    localparam int ADDR_WIDTH  = $clog2(H_PIXELS*V_PIXELS)
) (
    input  logic                   clk_in,
    input  logic                   rst_in,
    input  logic                   start_in,
    input  logic                   cam_valid_in,
    input  logic [COLOR_DEPTH-1:0] cam_pxl_in,
    output logic                   cam_ready_out,
    output logic                   hist_rd_en_out,
    output logic [ADDR_WIDTH-1:0]  hist_addr_out,
    input  logic [COLOR_DEPTH-1:0] hist_data_in,
    output logic [COLOR_DEPTH-1:0] iir_history_out,
    output logic [COLOR_DEPTH-1:0] iir_camera_out,
    input  logic [COLOR_DEPTH-1:0] iir_update_in,
    output logic                   wr_en_out,
    output logic [ADDR_WIDTH-1:0]  wr_addr_out,
    output logic [COLOR_DEPTH-1:0] wr_data_out,
    output logic                   busy_out,
    output logic                   frame_done_out
`ifdef TRAIL_SEQ_STATS_EN
    ,
    output logic [15:0]            frame_count_out,
    output logic [31:0]            stall_count_out
`endif
);

    localparam int                    c_N_PIXELS  = H_PIXELS * V_PIXELS;
    localparam logic [ADDR_WIDTH-1:0] c_LAST_ADDR = ADDR_WIDTH'(c_N_PIXELS - 1);
    localparam int                    c_MEM_WIDTH = COLOR_DEPTH + ADDR_WIDTH;

    seq_state_t              r_state;
    seq_state_t              w_state_next;
    logic [ADDR_WIDTH-1:0]   r_addr;
    logic                    w_hs;
    logic                    w_last;

    logic                    w_mem_valid;
    logic [c_MEM_WIDTH-1:0]  w_mem_data;
    logic [COLOR_DEPTH-1:0]  w_mem_pxl;
    logic [ADDR_WIDTH-1:0]   w_mem_addr;
    logic                    w_mem_pending;

    logic                    w_wr_valid;
    logic [ADDR_WIDTH-1:0]   w_wr_addr;
    logic                    w_iir_pending;

    logic [COLOR_DEPTH-1:0]  r_cam_hold;
    logic [COLOR_DEPTH-1:0]  r_hist_hold;

    // A beat is accepted only while running; a reset cycle never starts a read.
    assign w_hs   = cam_valid_in & cam_ready_out & ~rst_in;
    assign w_last = (r_addr == c_LAST_ADDR);

    // State register.
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state: leave DRAIN once no beat remains behind the one now writing.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            IDLE:    if (start_in) w_state_next = RUN;
            RUN:     if (w_hs && w_last) w_state_next = DRAIN;
            DRAIN:   if (!(w_mem_pending || w_iir_pending)) w_state_next = DONE;
            DONE:    w_state_next = IDLE;
            default: w_state_next = IDLE;
        endcase
    end

    // State-decoded outputs.
    always_comb begin
        cam_ready_out  = (r_state == RUN);
        busy_out       = (r_state == RUN) || (r_state == DRAIN);
        frame_done_out = (r_state == DONE);
    end

    // Raster address counter; wraps after the last pixel so the next pass starts at 0.
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            r_addr <= '0;
        end else if (w_hs) begin
            r_addr <= w_last ? '0 : r_addr + ADDR_WIDTH'(1);
        end
    end

    assign hist_rd_en_out = w_hs;
    assign hist_addr_out  = r_addr;

    // Carry pixel and address alongside the outstanding history read.
    trail_delay_line #(
        .WIDTH (c_MEM_WIDTH),
        .DEPTH (MEM_LATENCY)
    ) u_mem_stage (
        .clk       (clk_in),
        .rst       (rst_in),
        .src_valid (w_hs),
        .src_data  ({cam_pxl_in, r_addr}),
        .dst_valid (w_mem_valid),
        .dst_data  (w_mem_data),
        .pending   (w_mem_pending)
    );

    assign {w_mem_pxl, w_mem_addr} = w_mem_data;

    // Remember the last pair shown to the IIR so the outputs hold on idle slots.
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            r_cam_hold  <= '0;
            r_hist_hold <= '0;
        end else if (w_mem_valid) begin
            r_cam_hold  <= w_mem_pxl;
            r_hist_hold <= hist_data_in;
        end
    end

    // Live path keeps the history pixel aligned exactly with the BRAM data.
    assign iir_camera_out  = w_mem_valid ? w_mem_pxl    : r_cam_hold;
    assign iir_history_out = w_mem_valid ? hist_data_in : r_hist_hold;

    // Carry the address across the IIR computation latency.
    trail_delay_line #(
        .WIDTH (ADDR_WIDTH),
        .DEPTH (IIR_LATENCY)
    ) u_iir_stage (
        .clk       (clk_in),
        .rst       (rst_in),
        .src_valid (w_mem_valid),
        .src_data  (w_mem_addr),
        .dst_valid (w_wr_valid),
        .dst_data  (w_wr_addr),
        .pending   (w_iir_pending)
    );

    // A reset cycle discards any write still in flight.
    assign wr_en_out   = w_wr_valid & ~rst_in;
    assign wr_addr_out = wr_en_out ? w_wr_addr     : '0;
    assign wr_data_out = wr_en_out ? iir_update_in : '0;

`ifdef TRAIL_SEQ_STATS_EN
    logic [15:0] r_frame_count;
    logic [31:0] r_stall_count;

    // Completed passes, counted in DONE and wrapping naturally.
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            r_frame_count <= '0;
        end else if (r_state == DONE) begin
            r_frame_count <= r_frame_count + 16'd1;
        end
    end

    // RUN cycles without a camera beat; restarted when a pass begins.
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            r_stall_count <= '0;
        end else if ((r_state == IDLE) && start_in) begin
            r_stall_count <= '0;
        end else if ((r_state == RUN) && !cam_valid_in) begin
            r_stall_count <= r_stall_count + 32'd1;
        end
    end

    assign frame_count_out = r_frame_count;
    assign stall_count_out = r_stall_count;
`else
    // Statistics counters are not built in this configuration.
`endif

endmodule
`default_nettype wire
